uart_tx_mmio: RTL and testbench
===============================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter on the data-RAM bus (MAR address, MDR/RAM data lines, wmem/rmem strobes).
//  Sits in parallel with memoria_ram and answers only its two mapped addresses.
//  The CPU writes bytes to a 4-entry FIFO; a serial engine shifts them out as 8N1 frames on tx.
//  Status readback lets programs poll before writing.
// PARAMETERS
//  BASE_ADDR   8'hF0   DATA register address; STATUS is at BASE_ADDR+1
//  CLK_DIV     16'd434 clk cycles per serial bit (>=2)
//  FIFO_AW     2       FIFO address width (depth = 2**FIFO_AW = 4)
// PORTS
//  clk      in     1  system clock, rising edge
//  reset    in     1  asynchronous, active-low; clears all state
//  addr     in     8  RAM address bus (from MAR)
//  data     inout  8  RAM data bus; driven only during a STATUS read, else 8'hZZ
//  w        in     1  write strobe (wmem), sampled on clk rise
//  r        in     1  read strobe (rmem), level
//  tx       out    1  serial line, idle high
//  tx_idle  out    1  high when FIFO empty and engine in IDLE
// BEHAVIOUR
//  Reset (reset=0, async): FIFO pointers/count=0, FSM=IDLE, tx=1, overrun=0, tx_idle=1, data=Z.
//   Reset mid-frame aborts the frame: tx goes 1 immediately and queued bytes are lost.
//  Write DATA (w=1, addr=BASE_ADDR) at edge N: if count<4, push data[7:0], count+1 after N.
//   If count==4 at edge N, the byte is dropped and overrun is set (sticky).
//   Full is evaluated before a same-edge pop, so a write in the pop cycle with count==4 is dropped.
//  Write STATUS: ignored. Writes to any other address: ignored.
//  Read STATUS (r=1, addr=BASE_ADDR+1): data driven combinationally with
//   {4'b0, overrun, busy, empty, full}; busy = FSM!=IDLE.
//   At the clk edge where r=1 and the address hits, overrun clears.
//   If a drop happens on that same edge, the set wins.
//  Read DATA: returns 8'h00, no side effect. Read of other addresses: data=Z.
//  FSM states IDLE, START, BITS, STOP; bit counter 3b; baud counter 16b counts 0..CLK_DIV-1.
//   IDLE: tx=1. On an edge with count>0: pop head into shift reg, go to START, baud=0.
//   START: tx=0 for CLK_DIV cycles, then BITS with bit=0.
//   BITS: tx=shift[0] (LSB first), shifting right every CLK_DIV cycles; after bit 7 go to STOP.
//   STOP: tx=1 for CLK_DIV cycles, then IDLE.
//   Frame = 10*CLK_DIV cycles. A queued next byte pops on the first edge after IDLE is
//   re-entered, so there is 1 idle cycle between frames.
//  Latency: a write at edge N into an empty, idle unit is popped at edge N+1, and tx falls after N+1.
//  Push and pop on the same edge: count unchanged, pointers both advance and wrap mod 4.
//  tx is registered (no glitches). tx_idle = (count==0) && FSM==IDLE.
// TESTING (bench uses CLK_DIV=4)
//  1 reset=0 mid-frame -> tx=1, tx_idle=1, STATUS reads 8'h02.
//  2 write 8'hA5 to F0 -> tx low 4 clk, then 1,0,1,0,0,1,0,1 at 4 clk each, stop high 4 clk; total 40 clk.
//  3 five back-to-back writes while engine idle -> first pops; STATUS shows full=1 after 5th;
//    6th write drops, overrun=1.
//  4 read F1 after overrun -> data bit3=1; next read F1 -> bit3=0.
//  5 r=1 addr=8'h10 -> data=Z; w=1 addr=8'hF1 -> no FIFO change.
//  6 writes 11,22,33 queued -> three frames, 1 idle clk between each, bytes in order; tx_idle rises after last stop.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the data-RAM bus: a DATA register feeds a small FIFO,
// and a STATUS register lets software poll for space and pick up the sticky overrun flag.
module uart_tx_mmio #(
    parameter logic [7:0]  BASE_ADDR = 8'hF0,
    parameter logic [15:0] CLK_DIV   = 16'd434,
    parameter int          FIFO_AW   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    inout  wire  [7:0] data,
    input  logic       w,
    input  logic       r,
    output logic       tx,
    output logic       tx_idle
);

    localparam int                DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]  CNT_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

    state_t               state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [2:0]           bitCnt_q, bitCnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic [FIFO_AW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           mem_q [DEPTH];

    logic hitData, hitStatus, full, empty, push, drop, pop, baudLast;
    logic [7:0] status, busVal;
    logic busDrive;

    assign hitData   = (addr == BASE_ADDR);
    assign hitStatus = (addr == (BASE_ADDR + 8'd1));
    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    // Fullness is judged on the registered count, so a pop on the same edge cannot make room.
    assign push      = w && hitData && !full;
    assign drop      = w && hitData && full;
    assign pop       = (state_q == IDLE) && !empty;
    assign baudLast  = (baud_q == (CLK_DIV - 16'd1));

    assign status   = {4'b0000, overrun_q, (state_q != IDLE), empty, full};
    assign busDrive = r && (hitStatus || hitData);
    assign busVal   = hitStatus ? status : 8'h00;
    assign data     = busDrive ? busVal : 8'hzz;

    assign tx      = tx_q;
    assign tx_idle = empty && (state_q == IDLE);

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push) wrPtr_d = wrPtr_q + PTR_ONE;
        if (pop)  rdPtr_d = rdPtr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (drop)
            overrun_d = 1'b1;
        else if (r && hitStatus)
            overrun_d = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = mem_q[rdPtr_q];
                end
            end
            START: begin
                if (baudLast) begin
                    state_d  = BITS;
                    baud_d   = '0;
                    bitCnt_d = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            BITS: begin
                if (baudLast) begin
                    baud_d = '0;
                    if (bitCnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baudLast) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The line level follows the state being entered, so tx changes right on the transition edge.
        case (state_d)
            START:   tx_d = 1'b0;
            BITS:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= data;
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: bus tasks queue expected bytes, a line monitor decodes frames and
// compares them against that queue; register reads are checked directly.
module tb_uart_tx_mmio;

    localparam logic [15:0] DIV = 16'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       w = 1'b0;
    logic       r = 1'b0;
    logic       tbDrive = 1'b0;
    logic [7:0] tbData = 8'h00;
    wire  [7:0] data;
    logic       tx;
    logic       tx_idle;

    int         errCount = 0;
    int         checkCount = 0;
    int         cycleCnt = 0;
    int         writeEdge = 0;
    logic [7:0] expQ[$];
    int         startQ[$];
    logic       inFrame = 1'b0;
    logic [9:0] monBits;
    logic       monUnstable;
    logic       monAborted;
    logic [7:0] monExp;

    assign data = tbDrive ? tbData : 8'hzz;

    uart_tx_mmio #(
        .BASE_ADDR(8'hF0),
        .CLK_DIV  (DIV),
        .FIFO_AW  (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .data   (data),
        .w      (w),
        .r      (r),
        .tx     (tx),
        .tx_idle(tx_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act != exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] a,
                                 input logic [7:0] v, input logic drv);
        w       = wr;
        r       = rd;
        addr    = a;
        tbData  = v;
        tbDrive = drv;
    endtask

    task automatic endCycle();
        @(posedge clk);
        #1;
        w       = 1'b0;
        r       = 1'b0;
        addr    = 8'h00;
        tbDrive = 1'b0;
    endtask

    task automatic writeByte(input logic [7:0] a, input logic [7:0] v);
        applyStimulus(1'b1, 1'b0, a, v, 1'b1);
        endCycle();
        writeEdge = cycleCnt;
    endtask

    task automatic readCheck(input string name, input logic [7:0] a, input logic [7:0] exp,
                             input logic drv, input logic [7:0] v);
        applyStimulus(1'b0, 1'b1, a, v, drv);
        #1;
        checkOutput(name, int'(data), int'(exp));
        endCycle();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrained(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (expQ.size() == 0 && !inFrame && tx_idle) break;
            @(posedge clk);
            #1;
        end
        checkCount++;
        if (i == limit) begin
            errCount++;
            $display("[TB] FAIL %s: timeout with %0d bytes pending, required 0", name, expQ.size());
        end
    endtask

    // Line monitor: every frame must hold each of its ten slots steady for DIV samples and be
    // followed by at least one idle-high cycle; frames cut short by reset are discarded.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && tx == 1'b0) begin
                inFrame     = 1'b1;
                monUnstable = 1'b0;
                monAborted  = 1'b0;
                startQ.push_back(cycleCnt);
                for (int s = 0; s < 10; s++) begin
                    for (int k = 0; k < int'(DIV); k++) begin
                        if (s != 0 || k != 0) @(negedge clk);
                        if (!reset) monAborted = 1'b1;
                        if (k == 0) monBits[s] = tx;
                        else if (tx != monBits[s]) monUnstable = 1'b1;
                    end
                end
                @(negedge clk);
                if (!reset) monAborted = 1'b1;
                if (!monAborted) begin
                    checkOutput("start bit", int'(monBits[0]), 0);
                    checkOutput("stop bit", int'(monBits[9]), 1);
                    checkOutput("bit width stable", int'(monUnstable), 0);
                    checkOutput("idle gap", int'(tx), 1);
                    checkCount++;
                    if (expQ.size() == 0) begin
                        errCount++;
                        $display("[TB] FAIL unexpected frame: got %0h, expected none", monBits[8:1]);
                    end else begin
                        monExp = expQ.pop_front();
                        if (monBits[8:1] != monExp) begin
                            errCount++;
                            $display("[TB] FAIL frame byte: got %0h, expected %0h", monBits[8:1], monExp);
                        end
                    end
                end
                inFrame = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idleCycles(3);
        checkOutput("reset tx", int'(tx), 1);
        checkOutput("reset tx_idle", int'(tx_idle), 1);
        reset = 1'b1;
        idleCycles(2);
        readCheck("reset status", 8'hF1, 8'h02, 1'b0, 8'h00);

        // Reset mid-frame: line returns high at once and queued bytes vanish.
        writeByte(8'hF0, 8'h3C);
        writeByte(8'hF0, 8'h96);
        idleCycles(12);
        reset = 1'b0;
        #1;
        checkOutput("abort tx", int'(tx), 1);
        checkOutput("abort tx_idle", int'(tx_idle), 1);
        idleCycles(2);
        reset = 1'b1;
        idleCycles(1);
        readCheck("abort status", 8'hF1, 8'h02, 1'b0, 8'h00);
        idleCycles(60);
        checkOutput("after abort tx_idle", int'(tx_idle), 1);
        checkOutput("after abort no frame", int'(inFrame), 0);

        // Single byte: start bit appears one edge after the write edge.
        startQ.delete();
        expQ.push_back(8'hA5);
        writeByte(8'hF0, 8'hA5);
        waitDrained("drain A5", 100);
        checkOutput("A5 frame count", startQ.size(), 1);
        if (startQ.size() > 0) checkOutput("A5 start latency", startQ[0], writeEdge + 1);

        // Five back-to-back writes fill the FIFO; the sixth overruns.
        expQ.push_back(8'h5A);
        writeByte(8'hF0, 8'h5A);
        expQ.push_back(8'hC3);
        writeByte(8'hF0, 8'hC3);
        expQ.push_back(8'h0F);
        writeByte(8'hF0, 8'h0F);
        expQ.push_back(8'hF0);
        writeByte(8'hF0, 8'hF0);
        expQ.push_back(8'h81);
        writeByte(8'hF0, 8'h81);
        readCheck("status full", 8'hF1, 8'h05, 1'b0, 8'h00);
        writeByte(8'hF0, 8'hEE);
        readCheck("status overrun set", 8'hF1, 8'h0D, 1'b0, 8'h00);
        readCheck("status overrun cleared", 8'hF1, 8'h05, 1'b0, 8'h00);
        waitDrained("drain five", 400);

        // Decode boundaries: foreign reads float, DATA reads zero, stray writes ignored.
        readCheck("foreign read floats", 8'h10, 8'h3C, 1'b1, 8'h3C);
        readCheck("data read zero", 8'hF0, 8'h00, 1'b0, 8'h00);
        writeByte(8'hF1, 8'h77);
        writeByte(8'h10, 8'h66);
        idleCycles(3);
        checkOutput("stray write tx_idle", int'(tx_idle), 1);
        readCheck("stray write status", 8'hF1, 8'h02, 1'b0, 8'h00);

        // Three queued bytes go out in order with exactly one idle cycle between frames.
        startQ.delete();
        expQ.push_back(8'h11);
        writeByte(8'hF0, 8'h11);
        expQ.push_back(8'h22);
        writeByte(8'hF0, 8'h22);
        expQ.push_back(8'h33);
        writeByte(8'hF0, 8'h33);
        checkOutput("busy tx_idle", int'(tx_idle), 0);
        waitDrained("drain three", 300);
        checkOutput("three frame count", startQ.size(), 3);
        if (startQ.size() == 3) begin
            checkOutput("gap 1->2", startQ[1] - startQ[0], 41);
            checkOutput("gap 2->3", startQ[2] - startQ[1], 41);
        end
        checkOutput("final tx_idle", int'(tx_idle), 1);
        readCheck("final status", 8'hF1, 8'h02, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
